// File: rtl/serial_adder_pkg.sv
// Shared state encoding, default width and counter sizing for the bit-serial adder.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int cnt_width(input int w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle of the bit-serial adder; master drives operands, slave returns the result.
interface serial_adder_if #(
  parameter int WIDTH = serial_adder_pkg::DEFAULT_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/halfadder.sv
// Half-adder cell: s = a ^ b, c = a & b.
module halfadder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder from two half-adder cells; combinational, no state.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic w_s0;
  logic w_c0;
  logic w_c1;

  halfadder u_ha0 (.a(a),    .b(b),  .s(w_s0), .c(w_c0));
  halfadder u_ha1 (.a(w_s0), .b(ci), .s(s),    .c(w_c1));

  assign co = w_c0 | w_c1;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: {cout,sum} = a + b + cin, one bit per clock, LSB first.
// Latency WIDTH cycles from accepted start to done; start is ignored while busy (no queuing).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);
  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_s_sh;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_s_bit;
  logic             w_co;
  logic [WIDTH-1:0] w_s_next;

  full_adder u_fa (
    .a  (r_a_sh[0]),
    .b  (r_b_sh[0]),
    .ci (r_carry),
    .s  (w_s_bit),
    .co (w_co)
  );

  // New sum bit enters at the MSB so after WIDTH steps the LSB sits at bit 0.
  assign w_s_next = (r_s_sh >> 1) | (WIDTH'(w_s_bit) << (WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_s_sh  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_a_sh  <= bus.a;
            r_b_sh  <= bus.b;
            r_carry <= bus.cin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_a_sh  <= r_a_sh >> 1;
          r_b_sh  <= r_b_sh >> 1;
          r_s_sh  <= w_s_next;
          r_carry <= w_co;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_sum   <= w_s_next;
            r_cout  <= w_co;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH 8, 4 and 1: vector table, multi-cycle corner cases, exhaustive small widths.
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int sel   = 8;

  logic       t_start;
  logic [7:0] t_a;
  logic [7:0] t_b;
  logic       t_cin;

  serial_adder_if #(.WIDTH(8)) if8 ();
  serial_adder_if #(.WIDTH(4)) if4 ();
  serial_adder_if #(.WIDTH(1)) if1 ();

  assign if8.start = t_start && (sel == 8);
  assign if8.a     = t_a;
  assign if8.b     = t_b;
  assign if8.cin   = t_cin;
  assign if4.start = t_start && (sel == 4);
  assign if4.a     = t_a[3:0];
  assign if4.b     = t_b[3:0];
  assign if4.cin   = t_cin;
  assign if1.start = t_start && (sel == 1);
  assign if1.a     = t_a[0:0];
  assign if1.b     = t_b[0:0];
  assign if1.cin   = t_cin;

  serial_adder #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  serial_adder #(.WIDTH(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  serial_adder #(.WIDTH(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  logic       cur_busy;
  logic       cur_done;
  logic [8:0] cur_res;

  always_comb begin
    cur_busy = if8.busy;
    cur_done = if8.done;
    cur_res  = {if8.cout, if8.sum};
    case (sel)
      4: begin
        cur_busy = if4.busy;
        cur_done = if4.done;
        cur_res  = {4'b0, if4.cout, if4.sum};
      end
      1: begin
        cur_busy = if1.busy;
        cur_done = if1.done;
        cur_res  = {7'b0, if1.cout, if1.sum};
      end
      default: ;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the done cycle, ready for the next start.
  task automatic op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                    input logic [8:0] exp, input logic [8:0] prev, input string nm);
    int   n;
    logic ok;
    t_start = 1'b1; t_a = a; t_b = b; t_cin = cin;
    @(negedge clk);
    t_start = 1'b0;
    chk({nm, " busy rise"}, cur_busy, 1);
    n  = 0;
    ok = 1'b1;
    while (!cur_done && n < sel + 4) begin
      if (cur_res !== prev || !cur_busy) ok = 1'b0;
      @(negedge clk);
      n++;
    end
    chk({nm, " hold"}, ok, 1);
    chk({nm, " latency"}, n, sel);
    chk({nm, " result"}, cur_res, exp);
    chk({nm, " busy in done"}, cur_busy, 1);
    @(negedge clk);
    chk({nm, " done/busy fall"}, {cur_done, cur_busy}, 0);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [8:0] exp;
  } vec_t;

  initial begin
    vec_t       vecs[7];
    logic [8:0] prev;
    int         n;
    logic       ok;

    vecs[0] = '{8'h00, 8'h00, 1'b0, 9'h000};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 9'h100};
    vecs[2] = '{8'hA5, 8'h5A, 1'b1, 9'h100};
    vecs[3] = '{8'h3C, 8'h42, 1'b0, 9'h07E};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 9'h100};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 9'h1FF};
    vecs[6] = '{8'h12, 8'h34, 1'b1, 9'h047};

    rst_n = 1'b0; t_start = 1'b0; t_a = '0; t_b = '0; t_cin = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset w8", {if8.busy, if8.done, if8.cout, if8.sum}, 0);
    chk("reset w4", {if4.busy, if4.done, if4.cout, if4.sum}, 0);
    chk("reset w1", {if1.busy, if1.done, if1.cout, if1.sum}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    sel  = 8;
    prev = '0;
    foreach (vecs[i]) begin
      op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp, prev, "vec");
      prev = vecs[i].exp;
    end

    // Junk starts through SHIFT and the done cycle must not disturb 01+02.
    t_start = 1'b1; t_a = 8'h01; t_b = 8'h02; t_cin = 1'b0;
    @(negedge clk);
    t_a = 8'hFF; t_b = 8'hFF; t_cin = 1'b1;
    n = 0;
    while (!cur_done && n < 12) begin
      @(negedge clk);
      n++;
    end
    chk("ignored start latency", n, 8);
    chk("ignored start result", cur_res, 9'h003);
    @(negedge clk);
    chk("done-cycle start ignored", {cur_done, cur_busy}, 0);
    op(8'h10, 8'h20, 1'b0, 9'h030, 9'h003, "start after done");

    // Abort mid-computation with an asynchronous reset.
    t_start = 1'b1; t_a = 8'hFF; t_b = 8'hFF; t_cin = 1'b0;
    @(negedge clk);
    t_start = 1'b0;
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort outputs", {cur_busy, cur_done, cur_res}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (cur_done || cur_busy) ok = 1'b0;
    end
    chk("abort no done", ok, 1);
    op(8'h10, 8'h20, 1'b0, 9'h030, 9'h000, "post abort");

    sel  = 4;
    prev = '0;
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int c = 0; c < 2; c++) begin
          op(8'(x), 8'(y), c[0], 9'(x + y + c), prev, "w4");
          prev = 9'(x + y + c);
        end

    sel  = 1;
    prev = '0;
    for (int x = 0; x < 2; x++)
      for (int y = 0; y < 2; y++)
        for (int c = 0; c < 2; c++) begin
          op(8'(x), 8'(y), c[0], 9'(x + y + c), prev, "w1");
          prev = 9'(x + y + c);
        end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial N-bit adder that feeds our half-adder cells into a sequential datapath. It accepts two WIDTH-bit operands and a carry-in on a start strobe. It then processes one bit per clock, LSB first, through a full-adder cell built from two halfadder instances and a carry flip-flop. On completion it presents the registered sum and carry-out with a one-cycle done pulse. It sits downstream of halfadder and is the first multi-cycle arithmetic stage in the design.

## Interface
- WIDTH, 8, operand and sum width in bits (≥1)
- clk  input  1  rising-edge clock, single clock domain
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- cin  input  1  carry-in, captured on accepted start
- busy  output  1  high whenever state ≠ IDLE
- done  output  1  one-cycle pulse: sum/cout just updated
- sum  output  WIDTH  registered result, held until next completion
- cout  output  1  registered carry-out, held with sum

## Operation
- One clock and one reset: rst_n is asynchronous and active-low.
- While rst_n is low, all of the following are forced immediately:
  - state = IDLE
  - busy = 0, done = 0
  - sum = 0, cout = 0
  - shift registers, carry flip-flop and counter = 0
- **IDLE:**
  - If start = 1 at a clock edge: load a_sh ← a, b_sh ← b, carry ← cin, cnt ← 0; go to SHIFT.
  - Otherwise stay in IDLE.
- **SHIFT:** each edge does one bit step:
  - s_bit = a_sh[0] ^ b_sh[0] ^ carry
  - carry ← majority(a_sh[0], b_sh[0], carry)
  - a_sh and b_sh shift right; s_sh shifts right with s_bit entering at the MSB
  - cnt ← cnt + 1
  - On the edge where cnt == WIDTH-1: load sum ← {s_bit, s_sh[WIDTH-1:1]} and cout ← new carry; go to DONE.
- **DONE:** done = 1 for this cycle only. The next edge returns to IDLE.
- start is ignored in SHIFT and DONE. No queuing; the operand inputs are don't-care in those states.
- sum and cout change only on the completion edge. They keep the previous result for the whole computation.
- Arithmetic: {cout, sum} = a + b + cin, computed modulo 2^(WIDTH+1). Never overflows.
- WIDTH = 1: SHIFT lasts exactly one edge (cnt == 0 == WIDTH-1).
- Counter width is max(1, $clog2(WIDTH)).
- Reset asserted mid-operation: the computation is aborted, no done is produced, and outputs go to their reset values.

## Timing
- Let edge E0 be the edge that accepts start.
- busy rises after E0.
- Bit steps occur at edges E0+1 … E0+WIDTH.
- sum, cout and done become valid after edge E0+WIDTH.
- done and busy fall after E0+WIDTH+1 (back in IDLE).
- Latency from accepted start to done = WIDTH cycles.
- Earliest next accept is edge E0+WIDTH+2, so throughput is one operation per WIDTH+2 cycles.
- start held high continuously produces back-to-back operations at that rate.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package serial_adder_pkg holds:
  - state encoding constants: IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2
  - default WIDTH constant
- Sub-module full_adder (ports a, b, ci, s, co):
  - built from two halfadder instances plus an OR gate
  - provides s_bit and the next carry
- Top level holds the FSM, counter, shift registers and output registers.

## Test plan
- WIDTH=8, a=8'h00, b=8'h00, cin=0, one start pulse -> sum=8'h00, cout=0; done high for exactly one cycle, 8 cycles after the accepting edge; busy high for 9 cycles.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1 (carry ripples through every bit); sum keeps its old value until completion.
- a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, cout=1; then a=8'h3C, b=8'h42, cin=0 -> sum=8'h7E, cout=0.
- Start pulses with different operands during SHIFT and in the done cycle -> ignored, result equals the first operation; a start one cycle after done is accepted normally.
- rst_n pulled low at bit step 4 of a=8'hFF, b=8'hFF -> sum=0, cout=0, busy=0 immediately, no done pulse; a following a=8'h10, b=8'h20 gives sum=8'h30, cout=0.
- WIDTH=4 and WIDTH=1 builds, exhaustive over a, b, cin -> {cout, sum} == a+b+cin for every case; done latency is 4 and 1 cycles respectively.
